sega_pad_reader: RTL and testbench
==================================

SEGA_PAD_READER -- requirements
Module: sega_pad_reader

Interface
REQ-001 Parameters SHALL be, one per line:
 POLL_CYCLES, 833333, idle cycles between scans (about 60 Hz at 50 MHz)
 SETTLE_CYCLES, 500, cycles each select level is held before sampling (10 us at 50 MHz); minimum 3
REQ-002 Ports SHALL be, one per line:
 clk  input  1  system clock, 50 MHz
 reset  input  1  synchronous, active-high reset
 pad_in  input  6  raw controller pins, active-low, pulled up: [0] pin1, [1] pin2, [2] pin3, [3] pin4, [4] pin6, [5] pin9
 pad_sel  output  1  controller SELECT line (pin7)
 btn_up, btn_down, btn_left, btn_right  output  1 each  direction buttons, active-high
 btn_a, btn_b, btn_c, btn_start  output  1 each  face and start buttons, active-high
 present  output  1  a 3-button pad is detected
 valid  output  1  one-cycle pulse marking a new button snapshot
REQ-003 One clock and one reset SHALL be used; reset SHALL be synchronous and active-high. This is already decided.

Function
REQ-004 pad_in SHALL pass through a two-flop synchronizer before any use; all "sampled" values below refer to synchronizer outputs.
REQ-005 The FSM SHALL have four states: IDLE, SEL_HI, SEL_LO, UPD.
REQ-006 IDLE: pad_sel=1, held POLL_CYCLES cycles, then go to SEL_HI.
REQ-007 SEL_HI: pad_sel=1, held SETTLE_CYCLES cycles; on the last cycle capture the synchronized pins into hi_sample, then go to SEL_LO.
REQ-008 SEL_LO: pad_sel=0, held SETTLE_CYCLES cycles; on the last cycle capture the synchronized pins into lo_sample, then go to UPD.
REQ-009 UPD: pad_sel=1 for one cycle; at the clock edge leaving UPD load all button outputs and present; go to IDLE.
REQ-010 The frame period SHALL be exactly POLL_CYCLES + 2*SETTLE_CYCLES + 1 cycles.
REQ-011 pad_sel SHALL be low for exactly SETTLE_CYCLES consecutive cycles per frame.
REQ-012 valid SHALL be high for exactly one cycle: the first cycle in which the new outputs are visible.
REQ-013 Decode (all inverted, active-low to active-high):
 up=~hi[0], down=~hi[1], left=~hi[2], right=~hi[3], b=~hi[4], c=~hi[5], a=~lo[4], start=~lo[5].
REQ-014 present SHALL be (lo[3:2]==2'b00); a connected pad drives pins 3/4 low while SELECT is low.
REQ-015 When present=0, all eight btn_* outputs SHALL be 0, while valid still pulses.
REQ-016 Button outputs SHALL hold their value between valid pulses; pin changes after a capture affect only the next frame.
REQ-017 The timer SHALL be at most 20 bits wide, reload on each state entry and never wrap.

Reset
REQ-018 Reset SHALL force: state=IDLE, timer=0, pad_sel=1, all btn_*=0, present=0, valid=0, hi_sample and lo_sample = 6'h3F, synchronizer flops = 1.
REQ-019 Reset asserted in any state, including mid-SEL_LO, SHALL take effect at the next edge with no valid pulse; the frame restarts from IDLE.

Structure
REQ-020 A shared package game_pkg SHALL hold the FSM state encoding, the pad_in bit-index constants and the default timing constants.
REQ-021 The synchronizer SHALL be a sub-module sync_2ff, parameterized by width and reset value.

Verification (POLL_CYCLES=10, SETTLE_CYCLES=4)
REQ-022 Timing: pad_in=6'h3F constant -> valid every 19 cycles, pad_sel low exactly 4 cycles per frame, present=0, all btn_*=0.
REQ-023 Start only: pins 6'h3F during HI and 6'b010011 during LO -> after valid, btn_start=1, present=1, all other btn_*=0.
REQ-024 Left+B: pins 6'b101011 during HI and 6'b110011 during LO -> btn_left=1, btn_b=1, present=1, all others 0.
REQ-025 All buttons: pins 6'h00 during HI and 6'b000000 during LO -> all eight btn_*=1, present=1.
REQ-026 Reset in the 2nd SEL_LO cycle -> no valid that frame, pad_sel=1 next cycle, outputs 0, next valid 19 cycles after reset deasserts.
REQ-027 Pins change after the LO capture but before UPD -> outputs reflect the captured values; the change appears one frame later.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the Sega 3-button pad reader:
//   - FSM state encoding for the scan sequencer
//   - bit positions of the controller pins inside pad_in
//   - default scan timing and the timer width
//   - packed button snapshot type
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEL_HI = 2'd1,
        SEL_LO = 2'd2,
        UPD    = 2'd3
    } pad_state_t;

    // Positions of the controller pins inside the 6-bit pad_in bus.
    localparam int PAD_W    = 6;
    localparam int PIN1_IDX = 0;
    localparam int PIN2_IDX = 1;
    localparam int PIN3_IDX = 2;
    localparam int PIN4_IDX = 3;
    localparam int PIN6_IDX = 4;
    localparam int PIN9_IDX = 5;

    // Default timing for a 50 MHz clock.
    localparam int DEF_POLL_CYCLES   = 833333;   // ~60 Hz frame rate
    localparam int DEF_SETTLE_CYCLES = 500;      // 10 us per SELECT level

    // 20 bits covers the default poll interval (833333 < 2**20).
    localparam int TIMER_W = 20;

    // Button snapshot, all active-high.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic a;
        logic b;
        logic c;
        logic start;
    } pad_btn_t;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for asynchronous inputs, one flop pair per bit.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high; loads RESET_VAL into both stages
//   d_i    : asynchronous input bus
//   q_o    : synchronized output bus (two cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sega_pad_reader.sv
// ---------------------------------------------------------------------------
// sega_pad_reader
// Periodically scans a Sega 3-button controller. Each frame idles with
// SELECT high, holds SELECT high and samples, holds SELECT low and samples,
// then spends one cycle publishing the decoded snapshot.
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high
//   pad_in     : raw active-low controller pins (see game_pkg for bit map)
//   pad_sel    : SELECT line driven to the controller
//   btn_*      : decoded active-high buttons, held between snapshots
//   present    : a 3-button pad answered the SELECT-low probe
//   valid      : one-cycle pulse on the first cycle of a new snapshot
// ---------------------------------------------------------------------------
module sega_pad_reader
    import game_pkg::*;
#(
    parameter int POLL_CYCLES   = DEF_POLL_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES  // must be >= 3 to cover sync latency
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PAD_W-1:0] pad_in,
    output logic             pad_sel,
    output logic             btn_up,
    output logic             btn_down,
    output logic             btn_left,
    output logic             btn_right,
    output logic             btn_a,
    output logic             btn_b,
    output logic             btn_c,
    output logic             btn_start,
    output logic             present,
    output logic             valid
);

    // Timer counts up from 0 on every state entry; each state leaves on
    // its last count, so it never approaches the top of its range.
    localparam logic [TIMER_W-1:0] POLL_LAST   = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    logic [PAD_W-1:0]   pad_sync;

    pad_state_t         state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [PAD_W-1:0]   hi_q,     hi_d;
    logic [PAD_W-1:0]   lo_q,     lo_d;
    logic               pad_sel_q;
    logic               load_out;

    pad_btn_t           btn_q,    btn_d;
    logic               present_q, present_d;
    logic               valid_q;

    sync_2ff #(
        .WIDTH     (PAD_W),
        .RESET_VAL ({PAD_W{1'b1}})
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pad_in),
        .q_o   (pad_sync)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            hi_q      <= {PAD_W{1'b1}};
            lo_q      <= {PAD_W{1'b1}};
            pad_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            // Registered from the next state so SELECT lines up exactly
            // with the SEL_LO state and is glitch-free on the pin.
            pad_sel_q <= (state_d != SEL_LO);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TIMER_W'(1);
        hi_d     = hi_q;
        lo_d     = lo_q;
        load_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (timer_q == POLL_LAST) begin
                    state_d = SEL_HI;
                    timer_d = '0;
                end
            end
            SEL_HI: begin
                if (timer_q == SETTLE_LAST) begin
                    hi_d    = pad_sync;
                    state_d = SEL_LO;
                    timer_d = '0;
                end
            end
            SEL_LO: begin
                if (timer_q == SETTLE_LAST) begin
                    lo_d    = pad_sync;
                    state_d = UPD;
                    timer_d = '0;
                end
            end
            UPD: begin
                load_out = 1'b1;
                state_d  = IDLE;
                timer_d  = '0;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ---------------- Decode ----------------
    // With SELECT low a 3-button pad grounds pins 3 and 4; that is the
    // presence signature. Without it the buttons are forced released.
    always_comb begin
        present_d = (lo_q[PIN3_IDX] == 1'b0) && (lo_q[PIN4_IDX] == 1'b0);

        btn_d       = '0;
        btn_d.up    = ~hi_q[PIN1_IDX];
        btn_d.down  = ~hi_q[PIN2_IDX];
        btn_d.left  = ~hi_q[PIN3_IDX];
        btn_d.right = ~hi_q[PIN4_IDX];
        btn_d.b     = ~hi_q[PIN6_IDX];
        btn_d.c     = ~hi_q[PIN9_IDX];
        btn_d.a     = ~lo_q[PIN6_IDX];
        btn_d.start = ~lo_q[PIN9_IDX];

        if (!present_d) begin
            btn_d = '0;
        end
    end

    // Pins 1/2 repeat up/down while SELECT is low; they are not decoded.
    logic unused_lo_bits;
    assign unused_lo_bits = ^{lo_q[PIN2_IDX], lo_q[PIN1_IDX]};

    // ---------------- Output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q     <= '0;
            present_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= load_out;
            if (load_out) begin
                btn_q     <= btn_d;
                present_q <= present_d;
            end
        end
    end

    assign pad_sel   = pad_sel_q;
    assign btn_up    = btn_q.up;
    assign btn_down  = btn_q.down;
    assign btn_left  = btn_q.left;
    assign btn_right = btn_q.right;
    assign btn_a     = btn_q.a;
    assign btn_b     = btn_q.b;
    assign btn_c     = btn_q.c;
    assign btn_start = btn_q.start;
    assign present   = present_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_sega_pad_reader.sv
// ---------------------------------------------------------------------------
// tb_sega_pad_reader
// Bench for sega_pad_reader with POLL_CYCLES=10, SETTLE_CYCLES=4.
// A small controller model drives pad_in from the hi/lo pin patterns
// depending on pad_sel. Expected snapshots are queued when the pins are
// set and checked when valid pulses.
// ---------------------------------------------------------------------------
module tb_sega_pad_reader;

    localparam int POLL   = 10;
    localparam int SETTLE = 4;
    localparam int FRAME  = POLL + 2 * SETTLE + 1;

    logic       clk;
    logic       reset;
    logic [5:0] pad_in;
    logic       pad_sel;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       btn_a, btn_b, btn_c, btn_start;
    logic       present;
    logic       valid;

    logic [5:0] hi_pins;
    logic [5:0] lo_pins;

    sega_pad_reader #(
        .POLL_CYCLES   (POLL),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pad_in    (pad_in),
        .pad_sel   (pad_sel),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .btn_c     (btn_c),
        .btn_start (btn_start),
        .present   (present),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: the pad multiplexes its pins on SELECT.
    always_comb begin
        pad_in = pad_sel ? hi_pins : lo_pins;
    end

    typedef struct {
        string      name;
        logic [5:0] hi;
        logic [5:0] lo;
        logic [7:0] btn;    // {up,down,left,right,a,b,c,start}
        logic       pres;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] btn;
        logic       pres;
    } exp_t;

    vec_t vecs [8];
    exp_t sb_q [$];

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] got_btn();
        return {btn_up, btn_down, btn_left, btn_right, btn_a, btn_b, btn_c, btn_start};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, got);
        end
    endtask

    // Waits for the next valid pulse, counting cycles and SELECT-low cycles.
    task automatic wait_valid(output int cyc, output int lows);
        cyc  = 0;
        lows = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            cyc++;
            if (!pad_sel) lows++;
            if (valid) return;
        end
        total++;
        bad++;
        $display("FAIL valid_timeout: got=no valid expected=valid within 200 cycles");
    endtask

    task automatic wait_sel(input logic level);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pad_sel == level) return;
        end
        total++;
        bad++;
        $display("FAIL sel_timeout: got=pad_sel stuck expected=%0b within 200 cycles", level);
    endtask

    task automatic push_exp(input string nm, input logic [7:0] b, input logic p);
        exp_t e;
        e.name = nm;
        e.btn  = b;
        e.pres = p;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got=valid pulse expected=no pending snapshot");
            return;
        end
        e = sb_q.pop_front();
        chk({e.name, "_btn"}, {24'd0, got_btn()}, {24'd0, e.btn});
        chk({e.name, "_present"}, {31'd0, present}, {31'd0, e.pres});
    endtask

    initial begin
        int cyc;
        int lows;

        vecs[0] = '{"released",  6'h3F,      6'h3F,      8'b0000_0000, 1'b0};
        vecs[1] = '{"start",     6'h3F,      6'b010011,  8'b0000_0001, 1'b1};
        vecs[2] = '{"left_b",    6'b101011,  6'b110011,  8'b0010_0100, 1'b1};
        vecs[3] = '{"all",       6'h00,      6'b000000,  8'b1111_1111, 1'b1};
        vecs[4] = '{"masked",    6'h00,      6'b001111,  8'b0000_0000, 1'b0};
        vecs[5] = '{"up_a",      6'b111110,  6'b100011,  8'b1000_1000, 1'b1};
        vecs[6] = '{"half_sig",  6'b110101,  6'b000100,  8'b0000_0000, 1'b0};
        vecs[7] = '{"right_c",   6'b010111,  6'b110011,  8'b0001_0010, 1'b1};

        // ---------------- reset ----------------
        reset   = 1'b1;
        hi_pins = vecs[0].hi;
        lo_pins = vecs[0].lo;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pad_sel", {31'd0, pad_sel}, 32'd1);
        chk("rst_valid",   {31'd0, valid},   32'd0);
        chk("rst_present", {31'd0, present}, 32'd0);
        chk("rst_btn",     {24'd0, got_btn()}, 32'd0);
        reset = 1'b0;

        // ---------------- table-driven frames ----------------
        push_exp(vecs[0].name, vecs[0].btn, vecs[0].pres);
        wait_valid(cyc, lows);
        chk("frame0_period", cyc, FRAME);
        chk("frame0_sel_low", lows, SETTLE);
        sb_check();

        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("valid_one_cycle", {31'd0, valid}, 32'd0);
            hi_pins = vecs[i].hi;
            lo_pins = vecs[i].lo;
            push_exp(vecs[i].name, vecs[i].btn, vecs[i].pres);
            wait_valid(cyc, lows);
            chk({vecs[i].name, "_period"}, cyc + 1, FRAME);
            chk({vecs[i].name, "_sel_low"}, lows, SETTLE);
            sb_check();
        end

        // ---------------- reset in 2nd SEL_LO cycle ----------------
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);
        hi_pins = 6'h00;
        lo_pins = 6'h00;
        push_exp("after_reset", 8'hFF, 1'b1);
        wait_sel(1'b0);              // first SEL_LO cycle
        @(negedge clk);              // second SEL_LO cycle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midlo_rst_pad_sel", {31'd0, pad_sel}, 32'd1);
        chk("midlo_rst_valid",   {31'd0, valid},   32'd0);
        chk("midlo_rst_btn",     {24'd0, got_btn()}, 32'd0);
        chk("midlo_rst_present", {31'd0, present}, 32'd0);
        wait_valid(cyc, lows);
        chk("midlo_rst_period", cyc, FRAME);
        sb_check();

        // ---------------- pins change after LO capture ----------------
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);
        hi_pins = 6'h3F;
        lo_pins = 6'b010011;
        push_exp("captured", 8'b0000_0001, 1'b1);
        wait_sel(1'b0);
        wait_sel(1'b1);              // UPD cycle, both captures done
        chk("hold_before_upd", {24'd0, got_btn()}, 32'hFF);
        hi_pins = 6'h00;
        lo_pins = 6'h00;
        push_exp("late_change", 8'hFF, 1'b1);
        wait_valid(cyc, lows);
        chk("late_valid_latency", cyc, 1);
        sb_check();
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);
        wait_valid(cyc, lows);
        chk("late_period", cyc + 1, FRAME);
        sb_check();

        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
